// File: rtl/shift_reg_univ.sv
// Universal shift register (hold / shift right / shift left / parallel load) with a
// frame counter. Define SHIFT_REG_ROTATE_EN to let rot=1 turn a shift into a rotate.
module shift_reg_univ #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 CNT_W     = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic               si,
    input  logic               rot,
    input  logic [WIDTH-1:0]   d,
    output logic [WIDTH-1:0]   q,
    output logic               so,
    output logic [CNT_W-1:0]   cnt,
    output logic               frame_done
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    // Explicit wrap value so non-power-of-two widths do not run to 2^CNT_W-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    dir_e dir;
    logic in_bit;
    logic shifting;

`ifdef SHIFT_REG_ROTATE_EN
    always_comb begin
        in_bit = si;
        if (rot) begin
            in_bit = (mode == MODE_RIGHT) ? q[0] : q[WIDTH-1];
        end
    end
`else
    logic unused_rot;
    assign unused_rot = rot;
    assign in_bit     = si;
`endif

    assign shifting = en && ((mode == MODE_RIGHT) || (mode == MODE_LEFT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q          <= RESET_VAL;
            dir        <= DIR_RIGHT;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (en) begin
                case (mode)
                    MODE_RIGHT: begin
                        q   <= {in_bit, q[WIDTH-1:1]};
                        dir <= DIR_RIGHT;
                    end
                    MODE_LEFT: begin
                        q   <= {q[WIDTH-2:0], in_bit};
                        dir <= DIR_LEFT;
                    end
                    MODE_LOAD: begin
                        q   <= d;
                        cnt <= '0;
                    end
                    MODE_HOLD: ;
                    default: ;
                endcase
            end
            if (shifting) begin
                if (cnt == CNT_LAST) begin
                    cnt        <= '0;
                    frame_done <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // Serial output is a pure function of registered state, so it moves only after an edge.
    assign so = (dir == DIR_LEFT) ? q[WIDTH-1] : q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: an 8-bit instance (RESET_VAL 8'hA5) and a 5-bit instance
// (RESET_VAL 5'h0B) driven in lockstep; directed table, hand sequences, then random.
module tb_shift_reg_univ;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       si;
    logic       rot;
    logic [7:0] d;

    logic [7:0] q8;
    logic       so8;
    logic [2:0] cnt8;
    logic       fd8;
    logic [4:0] q5;
    logic       so5;
    logic [2:0] cnt5;
    logic       fd5;

    int checks = 0;
    int errors = 0;

    shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .si(si), .rot(rot), .d(d),
        .q(q8), .so(so8), .cnt(cnt8), .frame_done(fd8)
    );

    shift_reg_univ #(.WIDTH(5), .RESET_VAL(5'h0B)) dut5 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .si(si), .rot(rot), .d(d[4:0]),
        .q(q5), .so(so5), .cnt(cnt5), .frame_done(fd5)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: register as an integer, shifts done with arithmetic,
    // counter as a count of shifts modulo width
    typedef struct {
        int q;
        bit left;
        int cnt;
        bit fd;
    } mst_t;

    mst_t m8;
    mst_t m5;

    function automatic mst_t mreset(int rv);
        mst_t s;
        s.q = rv; s.left = 1'b0; s.cnt = 0; s.fd = 1'b0;
        return s;
    endfunction

    function automatic mst_t mstep(mst_t s, int w, bit e, bit [1:0] m, bit sib, bit rotb, int dd);
        mst_t n;
        int   mask;
        int   inb;
        n    = s;
        mask = (1 << w) - 1;
        n.fd = 1'b0;
        if (!e || m == 2'd0) return n;
        if (m == 2'd3) begin
            n.q   = dd & mask;
            n.cnt = 0;
            return n;
        end
        inb = sib ? 1 : 0;
`ifdef SHIFT_REG_ROTATE_EN
        if (rotb) inb = (m == 2'd1) ? (s.q & 1) : ((s.q >> (w - 1)) & 1);
`else
        if (rotb) inb = sib ? 1 : 0;
`endif
        if (m == 2'd1) begin
            n.q    = (s.q >> 1) | (inb << (w - 1));
            n.left = 1'b0;
        end else begin
            n.q    = ((s.q << 1) | inb) & mask;
            n.left = 1'b1;
        end
        n.cnt = (s.cnt + 1) % w;
        n.fd  = (n.cnt == 0);
        return n;
    endfunction

    function automatic int mso(mst_t s, int w);
        return s.left ? ((s.q >> (w - 1)) & 1) : (s.q & 1);
    endfunction

    // scoreboard helpers
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("m8_q",   int'(q8),   m8.q);
        check("m8_cnt", int'(cnt8), m8.cnt);
        check("m8_fd",  int'(fd8),  int'(m8.fd));
        check("m8_so",  int'(so8),  mso(m8, 8));
        check("m5_q",   int'(q5),   m5.q);
        check("m5_cnt", int'(cnt5), m5.cnt);
        check("m5_fd",  int'(fd5),  int'(m5.fd));
        check("m5_so",  int'(so5),  mso(m5, 5));
    endtask

    // driver: apply one command, let one edge sample it, compare against the model
    task automatic step(input bit e, input bit [1:0] m, input bit s, input bit r, input bit [7:0] dd);
        en = e; mode = m; si = s; rot = r; d = dd;
        @(posedge clk);
        #1;
        m8 = mstep(m8, 8, e, m, s, r, int'(dd));
        m5 = mstep(m5, 5, e, m, s, r, int'(dd[4:0]));
        check_model();
    endtask

    // asynchronous reset asserted between edges; outputs must clear without an edge
    task automatic reset_mid(input string tag);
        #3 rst = 1'b0;
        #1;
        check({tag, "_q"},   int'(q8),   'hA5);
        check({tag, "_cnt"}, int'(cnt8), 0);
        check({tag, "_fd"},  int'(fd8),  0);
        m8 = mreset('hA5);
        m5 = mreset('h0B);
        check_model();
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        bit       e;
        bit [1:0] m;
        bit       s;
        bit       r;
        bit [7:0] dd;
        bit [7:0] eq;
        int       ecnt;
        bit       efd;
        bit       eso;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit e, bit [1:0] m, bit s, bit [7:0] dd,
                                bit [7:0] eq, int ecnt, bit efd, bit eso);
        vec_t v;
        v.e = e; v.m = m; v.s = s; v.r = 1'b0; v.dd = dd;
        v.eq = eq; v.ecnt = ecnt; v.efd = efd; v.eso = eso;
        tbl.push_back(v);
    endfunction

    initial begin
        int fdc;
        bit e;
        bit [1:0] m;
        int sel;

        rst = 1'b1; en = 1'b0; mode = 2'd0; si = 1'b0; rot = 1'b0; d = 8'h00;

        // SIPO right from 8'hA5: si 1,0,1,1,0,0,1,0
        add(1, 1, 1, 0, 8'hD2, 1, 0, 0);
        add(1, 1, 0, 0, 8'h69, 2, 0, 1);
        add(1, 1, 1, 0, 8'hB4, 3, 0, 0);
        add(1, 1, 1, 0, 8'hDA, 4, 0, 0);
        add(1, 1, 0, 0, 8'h6D, 5, 0, 1);
        add(1, 1, 0, 0, 8'h36, 6, 0, 0);
        add(1, 1, 1, 0, 8'h9B, 7, 0, 1);
        add(1, 1, 0, 0, 8'h4D, 0, 1, 1);
        add(1, 0, 1, 0, 8'h4D, 0, 0, 1);
        // PISO left: load C3, so reads 1,1,0,0,0,0,1,1 before each shift
        add(1, 3, 0, 8'hC3, 8'hC3, 0, 0, 1);
        add(1, 2, 0, 0, 8'h86, 1, 0, 1);
        add(1, 2, 0, 0, 8'h0C, 2, 0, 0);
        add(1, 2, 0, 0, 8'h18, 3, 0, 0);
        add(1, 2, 0, 0, 8'h30, 4, 0, 0);
        add(1, 2, 0, 0, 8'h60, 5, 0, 0);
        add(1, 2, 0, 0, 8'hC0, 6, 0, 1);
        add(1, 2, 0, 0, 8'h80, 7, 0, 1);
        add(1, 2, 0, 0, 8'h00, 0, 1, 0);
        // load at wrap: 7 shifts then load 3C, no pulse
        add(1, 2, 1, 0, 8'h01, 1, 0, 0);
        add(1, 2, 1, 0, 8'h03, 2, 0, 0);
        add(1, 2, 1, 0, 8'h07, 3, 0, 0);
        add(1, 2, 1, 0, 8'h0F, 4, 0, 0);
        add(1, 2, 1, 0, 8'h1F, 5, 0, 0);
        add(1, 2, 1, 0, 8'h3F, 6, 0, 0);
        add(1, 2, 1, 0, 8'h7F, 7, 0, 0);
        add(1, 3, 0, 8'h3C, 8'h3C, 0, 0, 0);
        add(1, 0, 0, 0, 8'h3C, 0, 0, 0);
        // enable/hold: 4 shifts, en=0 x3, hold x2, 4 more shifts -> pulse 5 cycles late
        add(1, 1, 0, 0, 8'h1E, 1, 0, 0);
        add(1, 1, 0, 0, 8'h0F, 2, 0, 1);
        add(1, 1, 0, 0, 8'h07, 3, 0, 1);
        add(1, 1, 0, 0, 8'h03, 4, 0, 1);
        add(0, 1, 1, 0, 8'h03, 4, 0, 1);
        add(0, 1, 1, 0, 8'h03, 4, 0, 1);
        add(0, 3, 1, 8'hFF, 8'h03, 4, 0, 1);
        add(1, 0, 1, 0, 8'h03, 4, 0, 1);
        add(1, 0, 1, 0, 8'h03, 4, 0, 1);
        add(1, 1, 1, 0, 8'h81, 5, 0, 1);
        add(1, 1, 1, 0, 8'hC0, 6, 0, 0);
        add(1, 1, 1, 0, 8'hE0, 7, 0, 0);
        add(1, 1, 1, 0, 8'hF0, 0, 1, 0);
        add(1, 1, 0, 0, 8'h78, 1, 0, 0);

        // power-on reset
        #2 rst = 1'b0;
        #1;
        m8 = mreset('hA5);
        m5 = mreset('h0B);
        check("por_q", int'(q8), 'hA5);
        check("por_so", int'(so8), 1);
        check_model();
        @(negedge clk);
        rst = 1'b1;

        // reset while frame_done is high, then reset mid-frame
        for (int i = 0; i < 8; i++) step(1, 2'd1, 1'b0, 1'b0, 8'h00);
        check("fd_pre_reset", int'(fd8), 1);
        reset_mid("rst_fd");
        for (int i = 0; i < 3; i++) step(1, 2'd1, 1'b1, 1'b0, 8'h00);
        check("cnt_pre_reset", int'(cnt8), 3);
        reset_mid("rst_mid");

        // directed table
        foreach (tbl[i]) begin
            step(tbl[i].e, tbl[i].m, tbl[i].s, tbl[i].r, tbl[i].dd);
            check($sformatf("tbl%0d_q", i),   int'(q8),   int'(tbl[i].eq));
            check($sformatf("tbl%0d_cnt", i), int'(cnt8), tbl[i].ecnt);
            check($sformatf("tbl%0d_fd", i),  int'(fd8),  int'(tbl[i].efd));
            check($sformatf("tbl%0d_so", i),  int'(so8),  int'(tbl[i].eso));
        end

        // rotate request over a full frame
        step(1, 2'd3, 1'b0, 1'b0, 8'h81);
        fdc = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 2'd1, 1'b0, 1'b1, 8'h00);
            fdc += int'(fd8);
        end
`ifdef SHIFT_REG_ROTATE_EN
        check("rot_q", int'(q8), 'h81);
`else
        check("rot_q", int'(q8), 'h00);
`endif
        check("rot_fd_count", fdc, 1);

        // random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            e   = ($urandom_range(0, 7) != 0);
            sel = $urandom_range(0, 9);
            m   = (sel == 0) ? 2'd0 : (sel <= 4) ? 2'd1 : (sel <= 8) ? 2'd2 : 2'd3;
            step(e, m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
Parametrised universal shift register: the next generation of the team's single-bit serial shift register. It adds configurable width, left/right shift, parallel load and hold, plus a frame counter that flags when a full word has been shifted. It sits between serial links and parallel datapaths as a SIPO/PISO converter.

Parameters:
WIDTH, 8, register width in bits (>= 2).
RESET_VAL, 0, value of q after reset (WIDTH bits).
CNT_W, $clog2(WIDTH), width of the shift counter (>= 1).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-low reset.
en  input  1  clock enable; when 0 all state holds.
mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
si  input  1  serial input bit.
rot  input  1  rotate request (used only with SHIFT_REG_ROTATE_EN).
d  input  WIDTH  parallel load data.
q  output  WIDTH  register contents.
so  output  1  serial output bit.
cnt  output  CNT_W  shifts since last load/reset, modulo WIDTH.
frame_done  output  1  one-cycle pulse on the WIDTH-th shift.

Behaviour:
- Reset (rst=0, asynchronous, immediate, also mid-frame): q=RESET_VAL, dir=right, cnt=0, frame_done=0. Release is sampled synchronously; first active edge is the first clk rise with rst=1.
- All updates occur on the rising clk edge when en=1. With en=0: q, dir and cnt hold, and frame_done=0.
- mode 00 hold: q and cnt unchanged; frame_done=0.
- mode 01 shift right: q <= {in, q[WIDTH-1:1]}; dir <= right.
- mode 10 shift left: q <= {q[WIDTH-2:0], in}; dir <= left.
- in = si (see Optional Feature for rot).
- so is registered-path only: so = q[0] when dir=right, q[WIDTH-1] when dir=left. It is never combinational from mode. so changes only after a clock edge.
- Shift counter: each shift (01/10) increments cnt. When cnt==WIDTH-1 the shift wraps cnt to 0 and sets frame_done=1 for exactly that next cycle. Otherwise frame_done=0.
- A direction change mid-frame does not clear cnt.
- mode 11 load: q <= d, cnt <= 0, frame_done=0, dir unchanged.
- A load in the cycle cnt would wrap takes priority: no frame_done pulse.
- Latency: q, so, cnt and frame_done all reflect a command one cycle after the edge that samples it.
- Back-to-back frames: continuous shifting produces a frame_done pulse every WIDTH cycles with no gap.
- WIDTH not a power of two: cnt wraps explicitly at WIDTH-1, not at 2^CNT_W-1.

Optional Feature:
SHIFT_REG_ROTATE_EN
- Defined: when rot=1 during a shift, the bit shifted in is the bit leaving the register (q[0] for right, q[WIDTH-1] for left) and si is ignored. Counter and frame_done behave identically to a normal shift.
- Undefined: rot is present but ignored; in = si always.

Test Plan:
1. Reset mid-operation: WIDTH=8, RESET_VAL=8'hA5, shift 3 times, then pulse rst=0 between clock edges -> q=8'hA5, cnt=0, frame_done=0 immediately, without waiting for an edge.
2. SIPO right: shift 8 cycles with si=1,0,1,1,0,0,1,0 (first to last) -> q=8'b01001101; frame_done=1 exactly one cycle after the 8th shift edge, 0 otherwise.
3. PISO left: load d=8'hC3, then 8 left shifts with si=0 -> so sequence 1,1,0,0,0,0,1,1; final q=8'h00; cnt=0.
4. Enable/hold: during a shift sequence drop en for 3 cycles, then use mode 00 for 2 cycles -> q and cnt frozen; frame_done delayed by 5 cycles.
5. Load at wrap: after 7 shifts, apply mode 11 with d=8'h3C -> q=8'h3C, cnt=0, no frame_done pulse.
6. Rotate (SHIFT_REG_ROTATE_EN defined): load 8'h81, then 8 right shifts with rot=1 and si=0 -> q returns to 8'h81 and frame_done pulses once. With the macro undefined -> q=8'h00.
